// File: rtl/lfsr_bist_if.sv
// lfsr_bist_if: control, generator/checker and status signals of the LFSR BIST sequencer.
// o_lock_latency exists only when LFSR_BIST_LATENCY_EN is defined.
interface lfsr_bist_if #(parameter int NB_LFSR = 8);
   logic               i_start;
   logic               i_abort;
   logic [NB_LFSR-1:0] i_seed;
   logic [1:0]         i_valid_mode;
   logic               i_lock;
   logic [NB_LFSR-1:0] o_seed;
   logic               o_soft_reset;
   logic               o_valid;
   logic               o_busy;
   logic               o_done;
   logic               o_pass;
   logic [7:0]         o_loss_cnt;
   logic [2:0]         o_state;
`ifdef LFSR_BIST_LATENCY_EN
   logic [15:0]        o_lock_latency;
`endif
   modport master (
      output i_start, i_abort, i_seed, i_valid_mode, i_lock,
      input  o_seed, o_soft_reset, o_valid, o_busy, o_done, o_pass, o_loss_cnt, o_state
`ifdef LFSR_BIST_LATENCY_EN
      , input o_lock_latency
`endif
   );
   modport slave (
      input  i_start, i_abort, i_seed, i_valid_mode, i_lock,
      output o_seed, o_soft_reset, o_valid, o_busy, o_done, o_pass, o_loss_cnt, o_state
`ifdef LFSR_BIST_LATENCY_EN
      , output o_lock_latency
`endif
   );
endinterface

// File: rtl/lfsr_bist_controller.sv
// lfsr_bist_controller: seeds the LFSR generator, strobes valid and grades the checker lock.
// Define LFSR_BIST_LATENCY_EN to add the o_lock_latency capture.
module lfsr_bist_controller #(
   parameter int NB_LFSR      = 8,
   parameter int SEED_CYCLES  = 2,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int RUN_LENGTH   = 255,
   parameter int MAX_LOSS     = 4
) (
   input  logic       clk,
   input  logic       i_rst_n,
   lfsr_bist_if.slave bus
);
   localparam int SW = $clog2(SEED_CYCLES + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int RW = $clog2(RUN_LENGTH + 1);
   typedef enum logic [2:0] {IDLE = 3'd0, SEED = 3'd1, ACQUIRE = 3'd2, RUN = 3'd3, PASS = 3'd4, FAIL = 3'd5} state_t;
   state_t        state, nxt;
   logic [1:0]    ph, nxt_ph;
   logic [SW-1:0] scnt;
   logic [TW-1:0] tcnt;
   logic [RW-1:0] run_cnt, run_inc;
   logic [7:0]    loss_inc;
   logic          valid_nxt, start_acc;
`ifdef LFSR_BIST_LATENCY_EN
   logic          lat_done;
`endif
   always_comb begin
      loss_inc = (bus.o_loss_cnt == 8'hFF) ? bus.o_loss_cnt : bus.o_loss_cnt + 8'd1;
      run_inc  = run_cnt + RW'(bus.o_valid);
      case (state)
         IDLE, PASS, FAIL: nxt = bus.i_start ? SEED : state;
         SEED:             nxt = (scnt == SW'(SEED_CYCLES - 1)) ? ACQUIRE : SEED;
         ACQUIRE:          nxt = bus.i_lock ? RUN : (tcnt == TW'(LOCK_TIMEOUT - 1)) ? FAIL : ACQUIRE;
         RUN:              nxt = !bus.i_lock ? ((32'(loss_inc) >= MAX_LOSS) ? FAIL : ACQUIRE)
                                 : (run_inc == RW'(RUN_LENGTH)) ? PASS : RUN;
         default:          nxt = IDLE;
      endcase
      if (bus.i_abort) nxt = IDLE;
      start_acc = (nxt == SEED) && (state != SEED);
      // the phase restarts on every ACQUIRE entry so its first cycle is always a valid beat
      nxt_ph    = (nxt == ACQUIRE && state != ACQUIRE) ? 2'd0 : ph + 2'd1;
      valid_nxt = (nxt == ACQUIRE || nxt == RUN) &&
                  ((bus.i_valid_mode == 2'b01) ? !nxt_ph[0] : (bus.i_valid_mode == 2'b10) ? (nxt_ph == 2'd0) : 1'b1);
   end
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state            <= IDLE;
         ph               <= '0;
         scnt             <= '0;
         tcnt             <= '0;
         run_cnt          <= '0;
         bus.o_seed       <= {NB_LFSR{1'b1}};
         bus.o_soft_reset <= 1'b0;
         bus.o_valid      <= 1'b0;
         bus.o_busy       <= 1'b0;
         bus.o_done       <= 1'b0;
         bus.o_pass       <= 1'b0;
         bus.o_loss_cnt   <= '0;
         bus.o_state      <= '0;
`ifdef LFSR_BIST_LATENCY_EN
         bus.o_lock_latency <= '0;
         lat_done           <= 1'b0;
`endif
      end else begin
         state            <= nxt;
         ph               <= nxt_ph;
         scnt             <= (state == SEED && nxt == SEED) ? scnt + SW'(1) : '0;
         tcnt             <= (state == ACQUIRE && nxt == ACQUIRE) ? tcnt + TW'(1) : '0;
         run_cnt          <= (state == RUN && nxt == RUN) ? run_inc : '0;
         bus.o_soft_reset <= nxt == SEED;
         bus.o_valid      <= valid_nxt;
         bus.o_busy       <= nxt == SEED || nxt == ACQUIRE || nxt == RUN;
         bus.o_done       <= nxt == PASS || nxt == FAIL;
         bus.o_pass       <= nxt == PASS;
         bus.o_state      <= nxt;
         if (start_acc) begin
            bus.o_seed     <= (bus.i_seed == '0) ? {NB_LFSR{1'b1}} : bus.i_seed;
            bus.o_loss_cnt <= '0;
         end else if (state == RUN && !bus.i_lock && !bus.i_abort) begin
            bus.o_loss_cnt <= loss_inc;
         end
`ifdef LFSR_BIST_LATENCY_EN
         // only the first lock of a test is recorded; later re-acquisitions leave it alone
         if (start_acc) begin
            bus.o_lock_latency <= '0;
            lat_done           <= 1'b0;
         end else if (state == ACQUIRE && bus.i_lock && !lat_done) begin
            bus.o_lock_latency <= (32'(tcnt) > 32'hFFFF) ? 16'hFFFF : 16'(tcnt);
            lat_done           <= 1'b1;
         end
`endif
      end
   end
endmodule
